// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings and
// stream-format constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] CHECKSUM_INIT  = 8'h00;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects stream bytes MSB-first into a 32-bit word. Only the first three
// bytes are stored; the fourth byte is combined live into word_next_o so the
// loader can capture the complete word on the same edge that accepts it.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        clear_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_next_o,
    output logic        word_full_o
);

    logic [23:0] sreg_q;
    logic [1:0]  idx_q;

    assign word_next_o = {sreg_q, byte_i};
    // High when the byte currently offered would be the last byte of a word.
    assign word_full_o = (idx_q == 2'(BYTES_PER_WORD - 1));

    // Shift register and byte index; clear discards any partial word.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sreg_q <= '0;
            idx_q  <= '0;
        end else if (clear_i) begin
            sreg_q <= '0;
            idx_q  <= '0;
        end else if (shift_en_i) begin
            sreg_q <= {sreg_q[15:0], byte_i};
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte stream into the instruction RAM write port while
// holding the CPU. Stream: count byte, N big-endian words, XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = 8,
    parameter int WIDTH         = 32
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     we_,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [WIDTH-1:0]         wdata,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t                   state_q;
    logic                     byte_ready_q;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] waddr_q;
    logic [WIDTH-1:0]         wdata_q;
    logic                     cpu_hold_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    // One extra bit so that a count of 0 can represent a full DEPTH-word load.
    logic [ADDRESS_WIDTH:0]   remaining_q;
    logic [7:0]               csum_q;

    logic                     xfer;
    logic                     asm_clear;
    logic                     asm_shift;
    logic [31:0]              asm_word_next;
    logic                     asm_word_full;

    assign xfer      = byte_valid & byte_ready_q;
    // Partial words are dropped whenever the loader is idle or aborted.
    assign asm_clear = abort | (state_q == ST_IDLE);
    assign asm_shift = xfer & (state_q == ST_DATA);

    word_assembler u_asm (
        .clk         (clk),
        .rst_        (rst_),
        .clear_i     (asm_clear),
        .shift_en_i  (asm_shift),
        .byte_i      (byte_data),
        .word_next_o (asm_word_next),
        .word_full_o (asm_word_full)
    );

    assign byte_ready = byte_ready_q;
    assign we_        = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

    // Load FSM with registered outputs, counters and running checksum.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= ST_IDLE;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b1;
            waddr_q      <= '0;
            wdata_q      <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            remaining_q  <= '0;
            csum_q       <= CHECKSUM_INIT;
        end else if (abort) begin
            state_q      <= ST_IDLE;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b1;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    byte_ready_q <= 1'b0;
                    we_q         <= 1'b1;
                    if (start) begin
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        csum_q       <= CHECKSUM_INIT;
                        busy_q       <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        byte_ready_q <= 1'b1;
                        state_q      <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (xfer) begin
                        csum_q  <= csum_q ^ byte_data;
                        waddr_q <= '0;
                        if (byte_data == 8'd0)
                            remaining_q <= (ADDRESS_WIDTH+1)'(DEPTH);
                        else
                            remaining_q <= (ADDRESS_WIDTH+1)'(byte_data);
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ byte_data;
                        if (asm_word_full) begin
                            // Strobe goes low for the single WRITE cycle.
                            wdata_q      <= WIDTH'(asm_word_next);
                            we_q         <= 1'b0;
                            byte_ready_q <= 1'b0;
                            state_q      <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    we_q         <= 1'b1;
                    waddr_q      <= waddr_q + 1'b1;
                    remaining_q  <= remaining_q - 1'b1;
                    byte_ready_q <= 1'b1;
                    if (remaining_q == (ADDRESS_WIDTH+1)'(1))
                        state_q <= ST_CHECK;
                    else
                        state_q <= ST_DATA;
                end
                ST_CHECK: begin
                    if (xfer) begin
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        if (byte_data == csum_q) begin
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            // CPU stays held until the next start or abort.
                            err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    byte_ready_q <= 1'b0;
                    we_q         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued as the
// stream is issued and a monitor compares every write strobe against them.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_;
    logic        start;
    logic        abort;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we_;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  gap_mode = 0;

    imem_loader #(.DEPTH(256), .ADDRESS_WIDTH(8), .WIDTH(32)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .start      (start),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we_        (we_),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_ === 1'b1 && we_ === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {24'd0, waddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", {24'd0, waddr}, {24'd0, e.a});
                check("write_data", wdata, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        if (gap_mode != 0) repeat ($urandom_range(0, 3)) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        byte_valid = 1'b0;
        byte_data  = 8'hXX;
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Two-word program; checksum 02^34^01^00^0A^00^41^10^20 = 4C.
    task automatic load_two(input logic [7:0] csum);
        expect_write(8'd0, 32'h3401000A);
        expect_write(8'd1, 32'h00411020);
        pulse_start();
        send_byte(8'h02);
        send_word(32'h3401000A);
        send_word(32'h00411020);
        check("hold_before_csum", {31'd0, cpu_hold}, 32'd1);
        send_byte(csum);
    endtask

    initial begin
        rst_       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) tick();
        check("rst_we_",        {31'd0, we_},        32'd1);
        check("rst_waddr",      {24'd0, waddr},      32'd0);
        check("rst_wdata",      wdata,               32'd0);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_err",        {31'd0, err},        32'd0);
        rst_ = 1'b1;
        tick();

        // Back-to-back stream with a good checksum.
        load_two(8'h4C);
        check("t1_hold_falls", {31'd0, cpu_hold}, 32'd0);
        check("t1_done",       {31'd0, done},     32'd1);
        check("t1_err",        {31'd0, err},      32'd0);
        check("t1_busy",       {31'd0, busy},     32'd0);
        repeat (2) tick();

        // Same stream with random valid gaps, including mid-word stalls.
        gap_mode = 1;
        load_two(8'h4C);
        gap_mode = 0;
        check("t2_done",     {31'd0, done},     32'd1);
        check("t2_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        repeat (2) tick();

        // Corrupted checksum: writes still happen, CPU stays held.
        load_two(8'h4D);
        check("t3_err",  {31'd0, err},  32'd1);
        check("t3_done", {31'd0, done}, 32'd0);
        repeat (5) tick();
        check("t3_hold_kept", {31'd0, cpu_hold}, 32'd1);

        // Full-depth load (count 0); data = index, checksum 00.
        for (int i = 0; i < 256; i++) expect_write(8'(i), 32'(i));
        pulse_start();
        check("t4_err_cleared", {31'd0, err},      32'd0);
        check("t4_hold_on",     {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_word(32'(i));
        send_byte(8'h00);
        check("t4_done",     {31'd0, done},     32'd1);
        check("t4_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("t4_queue",    exp_q.size(),      32'd0);
        repeat (2) tick();

        // Abort halfway through word 1; a mid-load start must be ignored.
        expect_write(8'd0, 32'h11223344);
        pulse_start();
        send_byte(8'h02);
        send_word(32'h11223344);
        pulse_start();
        check("t5_busy_after_start", {31'd0, busy}, 32'd1);
        send_byte(8'h55);
        send_byte(8'h66);
        pulse_abort();
        check("t5_abort_busy", {31'd0, busy},     32'd0);
        check("t5_abort_hold", {31'd0, cpu_hold}, 32'd0);
        check("t5_abort_we_",  {31'd0, we_},      32'd1);
        check("t5_abort_done", {31'd0, done},     32'd0);
        repeat (8) tick();
        // Fresh N=1 load; checksum 01^DE^AD^BE^EF = 23.
        expect_write(8'd0, 32'hDEADBEEF);
        pulse_start();
        send_byte(8'h01);
        send_word(32'hDEADBEEF);
        send_byte(8'h23);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_err",  {31'd0, err},  32'd0);
        repeat (2) tick();

        // Asynchronous reset mid-DATA.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        rst_ = 1'b0;
        #1;
        check("t6_we_",        {31'd0, we_},        32'd1);
        check("t6_wdata",      wdata,               32'd0);
        check("t6_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("t6_busy",       {31'd0, busy},       32'd0);
        check("t6_cpu_hold",   {31'd0, cpu_hold},   32'd0);
        check("t6_done",       {31'd0, done},       32'd0);
        tick();
        tick();
        rst_ = 1'b1;
        tick();
        load_two(8'h4C);
        check("t6_reload_done", {31'd0, done},     32'd1);
        check("t6_reload_hold", {31'd0, cpu_hold}, 32'd0);
        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
